// File: rtl/pps_holdover_ctrl.sv
// 1PPS qualification and holdover controller: synchronizes pps_in, validates the
// edge-to-edge period, locks after consecutive good seconds and free-runs on loss.
module pps_holdover_ctrl #(
    parameter int C_CLOCK_FREQUENCY = 25000000,
    parameter int C_TOLERANCE       = 100,
    parameter int C_LOCK_COUNT      = 3,
    parameter int C_HOLDOVER_MAX    = 10
) (
    input  logic        ptp_clk,
    input  logic        ptp_resetn,
    input  logic        pps_in,
    output logic        pps_out,
    output logic        locked,
    output logic        holdover,
    output logic [31:0] pps_period,
    output logic        pps_err
);

    localparam int LP_CW = $clog2(C_CLOCK_FREQUENCY + C_TOLERANCE + 1);
    localparam int LP_GW = $clog2(C_LOCK_COUNT + 1);
    localparam int LP_SW = $clog2(C_HOLDOVER_MAX + 1);

    localparam logic [LP_CW-1:0] LP_CNT_TMO   = LP_CW'(C_CLOCK_FREQUENCY + C_TOLERANCE);
    localparam logic [LP_CW-1:0] LP_CNT_WRAP  = LP_CW'(C_CLOCK_FREQUENCY - 1);
    localparam logic [LP_CW-1:0] LP_CNT_HO    = LP_CW'(C_TOLERANCE + 1);
    localparam logic [LP_CW-1:0] LP_PH_EARLY  = LP_CW'(C_TOLERANCE);
    localparam logic [LP_CW-1:0] LP_PH_LATE   = LP_CW'(C_CLOCK_FREQUENCY - C_TOLERANCE);
    localparam logic [31:0]      LP_P_MIN     = 32'(C_CLOCK_FREQUENCY - C_TOLERANCE);
    localparam logic [31:0]      LP_P_MAX     = 32'(C_CLOCK_FREQUENCY + C_TOLERANCE);
    localparam logic [LP_GW-1:0] LP_GOOD_LOCK = LP_GW'(C_LOCK_COUNT);
    localparam logic [LP_SW-1:0] LP_SECS_MAX  = LP_SW'(C_HOLDOVER_MAX);

    typedef enum logic [1:0] {
        ST_SEARCH   = 2'd0,
        ST_VALIDATE = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [1:0]       r_vld;
    logic             r_armed;
    state_t           r_state;
    logic [LP_CW-1:0] r_cnt;
    logic [LP_GW-1:0] r_good;
    logic [LP_SW-1:0] r_secs;
    logic             r_pps_out;
    logic             r_pps_err;
    logic             r_locked;
    logic             r_holdover;
    logic [31:0]      r_pps_period;

    logic             w_edge;
    logic [31:0]      w_period;
    logic             w_period_ok;
    logic [LP_GW-1:0] w_good_inc;
    state_t           w_state_nxt;
    logic [LP_CW-1:0] w_cnt_nxt;
    logic [LP_GW-1:0] w_good_nxt;
    logic [LP_SW-1:0] w_secs_nxt;
    logic             w_pulse;
    logic             w_err;
    logic             w_period_ld;

    // Input synchronizer and edge register; edges are armed only once a low level
    // sampled after reset has been seen, so a level held high across reset is ignored.
    always_ff @(posedge ptp_clk or negedge ptp_resetn) begin
        if (!ptp_resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= pps_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | (r_vld[1] & ~r_sync2);
        end
    end

    assign w_edge      = r_sync2 & ~r_sync3 & r_armed;
    assign w_period    = 32'(r_cnt) + 32'd1;
    assign w_period_ok = (w_period >= LP_P_MIN) && (w_period <= LP_P_MAX);
    assign w_good_inc  = r_good + LP_GW'(1);

    // Next-state, counter and output-pulse decode; an edge wins over timeout or wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + LP_CW'(1);
        w_good_nxt  = r_good;
        w_secs_nxt  = r_secs;
        w_pulse     = 1'b0;
        w_err       = 1'b0;
        w_period_ld = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_edge) begin
                    w_cnt_nxt   = '0;
                    w_good_nxt  = '0;
                    w_state_nxt = ST_VALIDATE;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_VALIDATE: begin
                if (w_edge) begin
                    w_period_ld = 1'b1;
                    w_cnt_nxt   = '0;
                    if (w_period_ok) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == LP_GOOD_LOCK) begin
                            w_state_nxt = ST_LOCKED;
                            w_pulse     = 1'b1;
                        end else begin
                            w_state_nxt = ST_VALIDATE;
                        end
                    end else begin
                        w_err      = 1'b1;
                        w_good_nxt = '0;
                    end
                end else if (r_cnt == LP_CNT_TMO) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_state_nxt = ST_VALIDATE;
                end
            end
            ST_LOCKED: begin
                if (w_edge) begin
                    w_period_ld = 1'b1;
                    w_cnt_nxt   = '0;
                    if (w_period_ok) begin
                        w_pulse = 1'b1;
                    end else begin
                        w_err       = 1'b1;
                        w_good_nxt  = '0;
                        w_state_nxt = ST_VALIDATE;
                    end
                end else if (r_cnt == LP_CNT_TMO) begin
                    // Missed second: keep the phase of the last edge, so cnt resumes at T+1.
                    w_cnt_nxt   = LP_CNT_HO;
                    w_secs_nxt  = LP_SW'(1);
                    w_pulse     = 1'b1;
                    w_state_nxt = ST_HOLDOVER;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_HOLDOVER: begin
                if (w_edge) begin
                    w_period_ld = 1'b1;
                    w_cnt_nxt   = '0;
                    if (r_cnt <= LP_PH_EARLY) begin
                        w_state_nxt = ST_LOCKED;
                    end else if (r_cnt >= LP_PH_LATE) begin
                        w_pulse     = 1'b1;
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_err       = 1'b1;
                        w_good_nxt  = '0;
                        w_state_nxt = ST_VALIDATE;
                    end
                end else if (r_cnt == LP_CNT_WRAP) begin
                    w_cnt_nxt = '0;
                    if (r_secs == LP_SECS_MAX) begin
                        w_secs_nxt  = '0;
                        w_state_nxt = ST_SEARCH;
                    end else begin
                        w_secs_nxt = r_secs + LP_SW'(1);
                        w_pulse    = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_HOLDOVER;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_good_nxt  = '0;
                w_secs_nxt  = '0;
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge ptp_clk or negedge ptp_resetn) begin
        if (!ptp_resetn) begin
            r_state      <= ST_SEARCH;
            r_cnt        <= '0;
            r_good       <= '0;
            r_secs       <= '0;
            r_pps_out    <= 1'b0;
            r_pps_err    <= 1'b0;
            r_locked     <= 1'b0;
            r_holdover   <= 1'b0;
            r_pps_period <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_good     <= w_good_nxt;
            r_secs     <= w_secs_nxt;
            r_pps_out  <= w_pulse;
            r_pps_err  <= w_err;
            r_locked   <= (w_state_nxt == ST_LOCKED);
            r_holdover <= (w_state_nxt == ST_HOLDOVER);
            if (w_period_ld) begin
                r_pps_period <= w_period;
            end
        end
    end

    assign pps_out    = r_pps_out;
    assign pps_err    = r_pps_err;
    assign locked     = r_locked;
    assign holdover   = r_holdover;
    assign pps_period = r_pps_period;

endmodule

// File: tb/tb_pps_holdover_ctrl.sv
// Directed bench for pps_holdover_ctrl with F=1000, T=2, L=3, H=2: a vector table for
// period qualification plus hand sequences for holdover, phase windows and reset.
module tb_pps_holdover_ctrl;

    localparam int F = 1000;
    localparam int T = 2;
    localparam int L = 3;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pps_in = 1'b0;
    logic        pps_out;
    logic        locked;
    logic        holdover;
    logic [31:0] pps_period;
    logic        pps_err;

    int n_checks = 0;
    int n_fail   = 0;
    int since    = 0;
    int n_out    = 0;
    int n_err    = 0;
    int n0       = 0;
    int e0       = 0;

    typedef struct {
        int          gap;
        logic        e_out;
        logic        e_err;
        logic        e_lock;
        logic        e_hold;
        logic [31:0] e_per;
    } vec_t;

    vec_t tbl[15];

    pps_holdover_ctrl #(
        .C_CLOCK_FREQUENCY(F),
        .C_TOLERANCE      (T),
        .C_LOCK_COUNT     (L),
        .C_HOLDOVER_MAX   (H)
    ) dut (
        .ptp_clk   (clk),
        .ptp_resetn(rstn),
        .pps_in    (pps_in),
        .pps_out   (pps_out),
        .locked    (locked),
        .holdover  (holdover),
        .pps_period(pps_period),
        .pps_err   (pps_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pps_out) n_out <= n_out + 1;
        if (pps_err) n_err <= n_err + 1;
    end

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", tag, name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_out, input logic e_err,
                            input logic e_lock, input logic e_hold);
        chk(tag, "pps_out",  32'(pps_out),  32'(e_out));
        chk(tag, "pps_err",  32'(pps_err),  32'(e_err));
        chk(tag, "locked",   32'(locked),   32'(e_lock));
        chk(tag, "holdover", 32'(holdover), 32'(e_hold));
    endtask

    task automatic tick();
        @(negedge clk);
        since++;
    endtask

    // Raise pps_in 'gap' cycles after the previous rise; return when its result is visible.
    task automatic edge_start(input int gap);
        while (since < gap) tick();
        pps_in = 1'b1;
        since  = 0;
        repeat (3) tick();
    endtask

    task automatic edge_end();
        repeat (2) tick();
        pps_in = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        edge_start(v.gap);
        chk_outs(tag, v.e_out, v.e_err, v.e_lock, v.e_hold);
        chk(tag, "pps_period", pps_period, v.e_per);
        edge_end();
    endtask

    initial begin
        tbl[0]  = '{0,    1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000};
        tbl[2]  = '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000};
        tbl[3]  = '{1000, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1000};
        tbl[4]  = '{1000, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1000};
        tbl[5]  = '{1003, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1003};
        tbl[6]  = '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000};
        tbl[7]  = '{998,  1'b0, 1'b0, 1'b0, 1'b0, 32'd998};
        tbl[8]  = '{1002, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1002};
        tbl[9]  = '{997,  1'b0, 1'b1, 1'b0, 1'b0, 32'd997};
        tbl[10] = '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000};
        tbl[11] = '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000};
        tbl[12] = '{1000, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1000};
        tbl[13] = '{998,  1'b1, 1'b0, 1'b1, 1'b0, 32'd998};
        tbl[14] = '{1002, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1002};

        repeat (3) @(negedge clk);
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset", "pps_period", pps_period, 32'd0);
        rstn = 1'b1;
        repeat (10) tick();

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Holdover: missed-second pulse at +1003, wrap pulse at +2000, give up at +3000.
        n0 = n_out;
        while (since < 1005) tick();
        chk_outs("ho_pre", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_outs("ho_miss", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ho_miss1", "pps_out", 32'(pps_out), 32'd0);
        while (since < 2003) tick();
        chk_outs("ho_wrap", 1'b1, 1'b0, 1'b0, 1'b1);
        while (since < 3002) tick();
        chk_outs("ho_last", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("ho_exit", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        chk("ho_exit", "pulse_count", 32'(n_out - n0), 32'd2);

        // Relock, then re-acquire in holdover with the edge arriving at cnt=998.
        run_vec("relock0", '{0,    1'b0, 1'b0, 1'b0, 1'b0, 32'd1002});
        run_vec("relock1", '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000});
        run_vec("relock2", '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000});
        run_vec("relock3", '{1000, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1000});
        edge_start(1999);
        chk_outs("late_win", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("late_win", "pps_period", pps_period, 32'd999);
        tick();
        chk("late_win+1", "pps_out", 32'(pps_out), 32'd0);
        tick();
        chk("late_win+2", "pps_out", 32'(pps_out), 32'd0);
        pps_in = 1'b0;
        n0 = n_out;

        // Early window: edge at cnt=1 after the wrap pulse relocks with no extra pulse.
        run_vec("early_win", '{2002, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2});
        chk("early_win", "pulse_count", 32'(n_out - n0), 32'd2);

        // Out-of-window edge in holdover is rejected.
        run_vec("bad_phase", '{1500, 1'b0, 1'b1, 1'b0, 1'b0, 32'd500});
        run_vec("val_good",  '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000});

        // Reset mid-VALIDATE with pps_in held high across release.
        while (since < 100) tick();
        pps_in = 1'b1;
        repeat (2) tick();
        rstn = 1'b0;
        #1;
        chk_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid", "pps_period", pps_period, 32'd0);
        repeat (3) tick();
        rstn = 1'b1;
        n0 = n_out;
        e0 = n_err;
        repeat (20) tick();
        pps_in = 1'b0;
        repeat (20) tick();
        chk("rst_rel", "pulse_count", 32'(n_out - n0), 32'd0);
        chk("rst_rel", "err_count", 32'(n_err - e0), 32'd0);
        run_vec("fresh0", '{0,    1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        run_vec("fresh1", '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000});
        run_vec("fresh2", '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000});
        run_vec("fresh3", '{1000, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
